// File: rtl/apu_pkg.sv
// Shared types for the APU master control page: register select, register
// bit positions and the frame-sequencer step decode.
package apu_pkg;

  typedef enum logic [1:0] {
    REG_VOL  = 2'd0,
    REG_PAN  = 2'd1,
    REG_PWR  = 2'd2,
    REG_NONE = 2'd3
  } reg_sel_e;

  localparam int VOL_VIN_L_BIT = 7;
  localparam int VOL_L_LSB     = 4;
  localparam int VOL_VIN_R_BIT = 3;
  localparam int VOL_R_LSB     = 0;
  localparam int PAN_L_LSB     = 4;
  localparam int PAN_R_LSB     = 0;
  localparam int PWR_ON_BIT    = 7;
  localparam int PWR_FAST_BIT  = 4;

  localparam int TICK_LEN   = 2;
  localparam int TICK_SWEEP = 1;
  localparam int TICK_ENV   = 0;

  // Returns {len, sweep, env} for a sequencer step; the sweep pattern
  // follows steps 2/6 of every 8-step group, or step 2 alone for a 4-step loop.
  function automatic logic [2:0] fs_decode(input int unsigned step,
                                           input int unsigned steps);
    logic len;
    logic sweep;
    logic env;
    len = ((step % 2) == 0);
    if (steps == 4) sweep = (step == 2);
    else            sweep = ((step % 8) == 2) || ((step % 8) == 6);
    env = (step == steps - 1);
    return {len, sweep, env};
  endfunction

endpackage

// File: rtl/apu_master_ctrl_if.sv
// CPU register bus of the APU master control page.
interface apu_master_ctrl_if;
  // cpu_wr is a one-clock strobe that is always accepted (no ready/stall);
  // rdata is meaningful only while rdata_oe is high, which follows cpu_rd
  // combinationally for any reg_sel other than REG_NONE.
  logic       cpu_wr;
  logic       cpu_rd;
  logic [1:0] reg_sel;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rdata_oe;

  modport master (output cpu_wr, cpu_rd, reg_sel, wdata, input rdata, rdata_oe);
  modport slave  (input cpu_wr, cpu_rd, reg_sel, wdata, output rdata, rdata_oe);
endinterface

// File: rtl/apu_frame_seq.sv
// Frame sequencer: rising-edge detect on the tick level, step counter and
// registered single-cycle len/sweep/env pulses.
module apu_frame_seq
  import apu_pkg::*;
#(
  parameter int FS_STEPS = 8,
  localparam int STEP_W  = $clog2(FS_STEPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              run,
  input  logic              tick_lvl,
  output logic [STEP_W-1:0] step,
  output logic              len_tick,
  output logic              sweep_tick,
  output logic              env_tick
);

  logic              tick_prev_q, tick_prev_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [2:0]        pulse_q, pulse_d;
  logic              edge_det;

  always_comb begin
    tick_prev_d = tick_lvl;
    edge_det    = tick_lvl & ~tick_prev_q;
    step_d      = step_q;
    pulse_d     = '0;
    if (clr) begin
      step_d = '0;
    end else if (run && edge_det) begin
      pulse_d = fs_decode(32'(step_q), FS_STEPS);
      step_d  = step_q + STEP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_prev_q <= 1'b0;
      step_q      <= '0;
      pulse_q     <= '0;
    end else begin
      tick_prev_q <= tick_prev_d;
      step_q      <= step_d;
      pulse_q     <= pulse_d;
    end
  end

  assign step       = step_q;
  assign len_tick   = pulse_q[TICK_LEN];
  assign sweep_tick = pulse_q[TICK_SWEEP];
  assign env_tick   = pulse_q[TICK_ENV];

endmodule

// File: rtl/apu_master_ctrl.sv
// APU master control page: volume/pan/power registers, 2/1 MHz dividers,
// channel reset and frame sequencer. Optional macro: APU_FAST_SEQ_EN.
module apu_master_ctrl
  import apu_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int VOL_W    = 3,
  parameter int FS_STEPS = 8
) (
  input  logic                        apuv_4mhz,
  input  logic                        apu_reset,
  apu_master_ctrl_if.slave            bus,
  input  logic                        t1_nt2,
  input  logic                        fs_tick_in,
  input  logic [NUM_CH-1:0]           ch_active,
  output logic                        ajer_2mhz,
  output logic                        dyfa_1mhz,
  output logic                        apu_on,
  output logic                        ch_reset,
  output logic [VOL_W-1:0]            lvol,
  output logic [VOL_W-1:0]            rvol,
  output logic                        vin_l_ena,
  output logic                        vin_r_ena,
  output logic [NUM_CH-1:0]           lpan,
  output logic [NUM_CH-1:0]           rpan,
  output logic                        len_tick,
  output logic                        sweep_tick,
  output logic                        env_tick,
  output logic [$clog2(FS_STEPS)-1:0] fs_step
);

  logic              on_q, on_d;
  logic              vin_l_q, vin_l_d, vin_r_q, vin_r_d;
  logic [VOL_W-1:0]  lvol_q, lvol_d, rvol_q, rvol_d;
  logic [NUM_CH-1:0] lpan_q, lpan_d, rpan_q, rpan_d;
  logic              ajer_q, ajer_d, dyfa_q, dyfa_d;
  logic              fast_seq_q;
  logic              wr_vol, wr_pan, wr_pwr;
  logic [2:0]        lvol_ext, rvol_ext;
  logic [3:0]        lpan_ext, rpan_ext, stat_ext;
  logic              pwr_b4;
  logic [7:0]        rd_val;
  logic              tick_src;

  assign wr_vol = bus.cpu_wr && (bus.reg_sel == REG_VOL);
  assign wr_pan = bus.cpu_wr && (bus.reg_sel == REG_PAN);
  assign wr_pwr = bus.cpu_wr && (bus.reg_sel == REG_PWR);

  always_comb begin
    on_d    = on_q;
    vin_l_d = vin_l_q;
    vin_r_d = vin_r_q;
    lvol_d  = lvol_q;
    rvol_d  = rvol_q;
    lpan_d  = lpan_q;
    rpan_d  = rpan_q;
    ajer_d  = 1'b0;
    dyfa_d  = 1'b0;
    if (wr_pwr) on_d = bus.wdata[PWR_ON_BIT];
    if (!on_d) begin
      vin_l_d = 1'b0;
      vin_r_d = 1'b0;
      lvol_d  = '0;
      rvol_d  = '0;
      lpan_d  = '0;
      rpan_d  = '0;
    end else begin
      if (wr_vol) begin
        vin_l_d = bus.wdata[VOL_VIN_L_BIT];
        lvol_d  = bus.wdata[VOL_L_LSB +: VOL_W];
        vin_r_d = bus.wdata[VOL_VIN_R_BIT];
        rvol_d  = bus.wdata[VOL_R_LSB +: VOL_W];
      end
      if (wr_pan) begin
        lpan_d = bus.wdata[PAN_L_LSB +: NUM_CH];
        rpan_d = bus.wdata[PAN_R_LSB +: NUM_CH];
      end
    end
    // Dividers free-run only while power stays on; ajer_q high means it falls now.
    if (on_d && on_q) begin
      ajer_d = ~ajer_q;
      dyfa_d = ajer_q ? ~dyfa_q : dyfa_q;
    end
  end

`ifdef APU_FAST_SEQ_EN
  logic fast_seq_d;

  always_comb begin
    fast_seq_d = fast_seq_q;
    if (wr_pwr) begin
      if (bus.wdata[PWR_FAST_BIT] && t1_nt2) fast_seq_d = 1'b1;
      else if (!bus.wdata[PWR_FAST_BIT])     fast_seq_d = 1'b0;
    end
    if (!on_d) fast_seq_d = 1'b0;
  end

  always_ff @(posedge apuv_4mhz or posedge apu_reset) begin
    if (apu_reset) fast_seq_q <= 1'b0;
    else           fast_seq_q <= fast_seq_d;
  end

  assign pwr_b4 = t1_nt2 ? fast_seq_q : 1'b1;
`else
  logic unused_t1_nt2;

  assign unused_t1_nt2 = t1_nt2;
  assign fast_seq_q    = 1'b0;
  assign pwr_b4        = 1'b1;
`endif

  always_ff @(posedge apuv_4mhz or posedge apu_reset) begin
    if (apu_reset) begin
      on_q    <= 1'b0;
      vin_l_q <= 1'b0;
      vin_r_q <= 1'b0;
      lvol_q  <= '0;
      rvol_q  <= '0;
      lpan_q  <= '0;
      rpan_q  <= '0;
      ajer_q  <= 1'b0;
      dyfa_q  <= 1'b0;
    end else begin
      on_q    <= on_d;
      vin_l_q <= vin_l_d;
      vin_r_q <= vin_r_d;
      lvol_q  <= lvol_d;
      rvol_q  <= rvol_d;
      lpan_q  <= lpan_d;
      rpan_q  <= rpan_d;
      ajer_q  <= ajer_d;
      dyfa_q  <= dyfa_d;
    end
  end

  // Unstored volume bits read 0, unimplemented pan bits read 1.
  always_comb begin
    lvol_ext = '0;
    rvol_ext = '0;
    lpan_ext = '1;
    rpan_ext = '1;
    stat_ext = '0;
    lvol_ext[VOL_W-1:0]  = lvol_q;
    rvol_ext[VOL_W-1:0]  = rvol_q;
    lpan_ext[NUM_CH-1:0] = lpan_q;
    rpan_ext[NUM_CH-1:0] = rpan_q;
    if (on_q) stat_ext[NUM_CH-1:0] = ch_active;
    case (bus.reg_sel)
      REG_VOL: rd_val = {vin_l_q, lvol_ext, vin_r_q, rvol_ext};
      REG_PAN: rd_val = {lpan_ext, rpan_ext};
      REG_PWR: rd_val = {on_q, 2'b11, pwr_b4, stat_ext};
      default: rd_val = '0;
    endcase
  end

  assign bus.rdata    = bus.cpu_rd ? rd_val : 8'h00;
  assign bus.rdata_oe = bus.cpu_rd && (bus.reg_sel != REG_NONE);

  assign tick_src = fast_seq_q ? dyfa_q : fs_tick_in;

  apu_frame_seq #(.FS_STEPS(FS_STEPS)) u_frame_seq (
    .clk        (apuv_4mhz),
    .rst        (apu_reset),
    .clr        (~on_d),
    .run        (on_q & on_d),
    .tick_lvl   (tick_src),
    .step       (fs_step),
    .len_tick   (len_tick),
    .sweep_tick (sweep_tick),
    .env_tick   (env_tick)
  );

  assign apu_on    = on_q;
  assign ch_reset  = ~on_q;
  assign ajer_2mhz = ajer_q;
  assign dyfa_1mhz = dyfa_q;
  assign vin_l_ena = vin_l_q;
  assign vin_r_ena = vin_r_q;
  assign lvol      = lvol_q;
  assign rvol      = rvol_q;
  assign lpan      = lpan_q;
  assign rpan      = rpan_q;

endmodule

// File: tb/tb_apu_master_ctrl.sv
// Self-checking bench for apu_master_ctrl: register table, dividers, frame
// sequencer, power-off/tick collision and the APU_FAST_SEQ_EN fast mode.
module tb_apu_master_ctrl;
  import apu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       t1_nt2 = 1'b0;
  logic       fs_tick_in = 1'b0;
  logic [3:0] ch_active = 4'h0;
  logic       ajer_2mhz, dyfa_1mhz, apu_on, ch_reset;
  logic [2:0] lvol, rvol;
  logic       vin_l_ena, vin_r_ena;
  logic [3:0] lpan, rpan;
  logic       len_tick, sweep_tick, env_tick;
  logic [2:0] fs_step;

  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] exp_q[$];

  apu_master_ctrl_if bus ();

  apu_master_ctrl #(.NUM_CH(4), .VOL_W(3), .FS_STEPS(8)) dut (
    .apuv_4mhz (clk),
    .apu_reset (rst),
    .bus       (bus),
    .t1_nt2    (t1_nt2),
    .fs_tick_in(fs_tick_in),
    .ch_active (ch_active),
    .ajer_2mhz (ajer_2mhz),
    .dyfa_1mhz (dyfa_1mhz),
    .apu_on    (apu_on),
    .ch_reset  (ch_reset),
    .lvol      (lvol),
    .rvol      (rvol),
    .vin_l_ena (vin_l_ena),
    .vin_r_ena (vin_r_ena),
    .lpan      (lpan),
    .rpan      (rpan),
    .len_tick  (len_tick),
    .sweep_tick(sweep_tick),
    .env_tick  (env_tick),
    .fs_step   (fs_step)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] wsel;
    logic [7:0] wdata;
    logic [1:0] rsel;
    logic [3:0] chact;
    logic [7:0] exp_rd;
    logic       exp_on;
    logic [3:0] exp_lpan;
    logic [3:0] exp_rpan;
    logic [2:0] exp_lvol;
    logic [2:0] exp_rvol;
    logic [1:0] exp_vin;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [7:0] data);
    bus.reg_sel = sel;
    bus.wdata   = data;
    bus.cpu_wr  = 1'b1;
    cyc();
    bus.cpu_wr  = 1'b0;
  endtask

  task automatic rd(input logic [1:0] sel, output logic [7:0] d, output logic oe);
    bus.reg_sel = sel;
    bus.cpu_rd  = 1'b1;
    #1;
    d  = bus.rdata;
    oe = bus.rdata_oe;
    bus.cpu_rd = 1'b0;
  endtask

  // One fs_tick_in pulse (2 high, 2 low) and the tick cycles seen meanwhile.
  task automatic run_tick(output int c_len, output int c_sw, output int c_env);
    c_len = 0; c_sw = 0; c_env = 0;
    fs_tick_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) fs_tick_in = 1'b0;
      cyc();
      c_len += int'(len_tick);
      c_sw  += int'(sweep_tick);
      c_env += int'(env_tick);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       oe;
    logic [2:0] e_ticks;
    int cl, cs, ce, tot_len, tot_sw, tot_env, toggles_a, toggles_d;
    int last_chg, changes;
    logic prev_a, prev_d;
    logic [2:0] prev_step;

    vecs[0]  = '{REG_PWR, 8'h80, REG_PWR, 4'h5, 8'hF5, 1'b1, 4'h0, 4'h0, 3'd0, 3'd0, 2'b00};
    vecs[1]  = '{REG_PAN, 8'hF3, REG_PAN, 4'h5, 8'hF3, 1'b1, 4'hF, 4'h3, 3'd0, 3'd0, 2'b00};
    vecs[2]  = '{REG_VOL, 8'h77, REG_VOL, 4'h5, 8'h77, 1'b1, 4'hF, 4'h3, 3'd7, 3'd7, 2'b00};
    vecs[3]  = '{REG_VOL, 8'hA5, REG_VOL, 4'h5, 8'hA5, 1'b1, 4'hF, 4'h3, 3'd2, 3'd5, 2'b10};
    vecs[4]  = '{REG_PAN, 8'h5A, REG_PAN, 4'h5, 8'h5A, 1'b1, 4'h5, 4'hA, 3'd2, 3'd5, 2'b10};
    vecs[5]  = '{REG_PWR, 8'h80, REG_PAN, 4'h5, 8'h5A, 1'b1, 4'h5, 4'hA, 3'd2, 3'd5, 2'b10};
    vecs[6]  = '{REG_PWR, 8'h00, REG_PWR, 4'h5, 8'h70, 1'b0, 4'h0, 4'h0, 3'd0, 3'd0, 2'b00};
    vecs[7]  = '{REG_VOL, 8'h77, REG_VOL, 4'h5, 8'h00, 1'b0, 4'h0, 4'h0, 3'd0, 3'd0, 2'b00};
    vecs[8]  = '{REG_PAN, 8'hFF, REG_PAN, 4'h5, 8'h00, 1'b0, 4'h0, 4'h0, 3'd0, 3'd0, 2'b00};
    vecs[9]  = '{REG_PWR, 8'h8F, REG_PWR, 4'hF, 8'hFF, 1'b1, 4'h0, 4'h0, 3'd0, 3'd0, 2'b00};
    vecs[10] = '{REG_PWR, 8'h00, REG_PWR, 4'hF, 8'h70, 1'b0, 4'h0, 4'h0, 3'd0, 3'd0, 2'b00};

    bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0; bus.reg_sel = REG_NONE; bus.wdata = 8'h00;
    ch_active = 4'h5;
    repeat (3) cyc();
    rst = 1'b0;

    // reset state
    toggles_a = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      toggles_a += int'(ajer_2mhz) + int'(dyfa_1mhz);
    end
    check("rst_div_static", 32'(toggles_a), 0);
    check("rst_ch_reset", 32'(ch_reset), 1);
    check("rst_apu_on", 32'(apu_on), 0);
    check("rst_fs_step", 32'(fs_step), 0);
    rd(REG_PWR, d, oe);
    check("rst_rd_pwr", 32'(d), 32'h70);
    check("rst_rd_oe", 32'(oe), 1);
    rd(REG_NONE, d, oe);
    check("none_oe", 32'(oe), 0);

    // register table
    for (int i = 0; i < 11; i++) begin
      ch_active = vecs[i].chact;
      wr(vecs[i].wsel, vecs[i].wdata);
      rd(vecs[i].rsel, d, oe);
      check($sformatf("v%0d_rdata", i), 32'(d), 32'(vecs[i].exp_rd));
      check($sformatf("v%0d_oe", i), 32'(oe), 1);
      check($sformatf("v%0d_on", i), 32'(apu_on), 32'(vecs[i].exp_on));
      check($sformatf("v%0d_ch_reset", i), 32'(ch_reset), 32'(!vecs[i].exp_on));
      check($sformatf("v%0d_pan", i), 32'({lpan, rpan}), 32'({vecs[i].exp_lpan, vecs[i].exp_rpan}));
      check($sformatf("v%0d_vol", i), 32'({lvol, rvol}), 32'({vecs[i].exp_lvol, vecs[i].exp_rvol}));
      check($sformatf("v%0d_vin", i), 32'({vin_l_ena, vin_r_ena}), 32'(vecs[i].exp_vin));
    end

    // power-on edge and dividers
    wr(REG_PWR, 8'h80);
    check("pwron_on", 32'(apu_on), 1);
    check("pwron_ch_reset", 32'(ch_reset), 0);
    check("pwron_step", 32'(fs_step), 0);
    toggles_a = 0; toggles_d = 0;
    prev_a = ajer_2mhz; prev_d = dyfa_1mhz;
    for (int k = 0; k < 16; k++) begin
      cyc();
      if (ajer_2mhz != prev_a) toggles_a++;
      if (dyfa_1mhz != prev_d) toggles_d++;
      prev_a = ajer_2mhz; prev_d = dyfa_1mhz;
    end
    check("ajer_toggles", 32'(toggles_a), 16);
    check("dyfa_toggles", 32'(toggles_d), 8);

    // frame sequencer over a full period
    tot_len = 0; tot_sw = 0; tot_env = 0;
    for (int e = 0; e < 8; e++) begin
      exp_q.push_back({(e % 2 == 0), (e == 2 || e == 6), (e == 7)});
      run_tick(cl, cs, ce);
      e_ticks = exp_q.pop_front();
      check($sformatf("seq%0d_len", e), 32'(cl), 32'(e_ticks[2]));
      check($sformatf("seq%0d_sweep", e), 32'(cs), 32'(e_ticks[1]));
      check($sformatf("seq%0d_env", e), 32'(ce), 32'(e_ticks[0]));
      check($sformatf("seq%0d_step", e), 32'(fs_step), 32'((e + 1) % 8));
      tot_len += cl; tot_sw += cs; tot_env += ce;
    end
    check("seq_tot_len", 32'(tot_len), 4);
    check("seq_tot_sweep", 32'(tot_sw), 2);
    check("seq_tot_env", 32'(tot_env), 1);

    // power-off collides with a tick edge
    run_tick(cl, cs, ce);
    check("pre_off_step", 32'(fs_step), 1);
    bus.reg_sel = REG_PWR; bus.wdata = 8'h00; bus.cpu_wr = 1'b1;
    fs_tick_in = 1'b1;
    cl = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) fs_tick_in = 1'b0;
      cyc();
      bus.cpu_wr = 1'b0;
      cl += int'(len_tick) + int'(sweep_tick) + int'(env_tick);
    end
    check("off_tick_none", 32'(cl), 0);
    check("off_step", 32'(fs_step), 0);
    check("off_ch_reset", 32'(ch_reset), 1);
    check("off_div", 32'({ajer_2mhz, dyfa_1mhz}), 0);

    // simultaneous read and write shows the old value
    wr(REG_PWR, 8'h80);
    wr(REG_PAN, 8'h3C);
    bus.reg_sel = REG_PAN; bus.wdata = 8'hC3; bus.cpu_wr = 1'b1; bus.cpu_rd = 1'b1;
    #1;
    check("rdwr_old", 32'(bus.rdata), 32'h3C);
    cyc();
    bus.cpu_wr = 1'b0;
    #1;
    check("rdwr_new", 32'(bus.rdata), 32'hC3);
    bus.cpu_rd = 1'b0;
    wr(REG_PWR, 8'h00);

    // fast sequencer mode
    t1_nt2 = 1'b1;
    wr(REG_PWR, 8'h90);
    rd(REG_PWR, d, oe);
    check("fast_rd_b4", 32'(d[4]), 1);
`ifdef APU_FAST_SEQ_EN
    last_chg = -1; changes = 0; prev_step = fs_step;
    for (int c = 1; c <= 40; c++) begin
      cyc();
      if (fs_step != prev_step) begin
        check("fast_step_inc", 32'(fs_step), 32'(3'(prev_step + 3'd1)));
        if (last_chg >= 0) check("fast_interval", 32'(c - last_chg), 4);
        last_chg = c;
        changes++;
      end
      prev_step = fs_step;
    end
    check("fast_changes", 32'(changes >= 9), 1);
    wr(REG_PWR, 8'h80);
    rd(REG_PWR, d, oe);
    check("fast_clr_b4", 32'(d[4]), 0);
`endif
    prev_step = fs_step;
    changes = 0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (fs_step != prev_step) changes++;
    end
    check("slow_step_hold", 32'(changes), 0);
    wr(REG_PWR, 8'h00);
    check("final_off", 32'({apu_on, ch_reset}), 32'b01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apu_master_ctrl.md
Name: apu_master_ctrl

Overview:
- Parametrised successor to the APU control page. Holds the master volume/VIN register (NR50-class), the panning register (NR51-class) and the power/status register (NR52-class) for NUM_CH channels.
- Generates the APU 2 MHz and 1 MHz enables, the power-gated channel reset, and the 8-step frame sequencer (length/sweep/envelope ticks).
- Sits between the CPU register bus and the channel blocks.
- Replaces the latch-based register page with fully synchronous flops on the APU clock.

Parameters:
- NUM_CH, 4, number of channels (1..4); sets pan width per side and status bit count.
- VOL_W, 3, master volume width per side (1..3); held in bits [VOL_W-1:0] of each nibble.
- FS_STEPS, 8, frame sequencer period in steps (power of two, 4..16).

Ports:
- apuv_4mhz  in  1  APU clock; all flops rising-edge.
- apu_reset  in  1  asynchronous active-high reset.
- cpu_wr  in  1  write strobe, one clock wide.
- cpu_rd  in  1  read enable.
- reg_sel  in  2  register select: 0 = volume, 1 = pan, 2 = power/status, 3 = none.
- wdata  in  8  write data.
- rdata  out  8  read data; valid when rdata_oe is high.
- rdata_oe  out  1  high when cpu_rd is high and reg_sel != 3.
- t1_nt2  in  1  test-mode qualifier.
- fs_tick_in  in  1  frame tick level from the DIV block (512 Hz class).
- ch_active  in  NUM_CH  per-channel active flags.
- ajer_2mhz  out  1  2 MHz toggle.
- dyfa_1mhz  out  1  1 MHz toggle.
- apu_on  out  1  master power.
- ch_reset  out  1  high while powered off; holds channels in reset.
- lvol, rvol  out  VOL_W each  master volumes.
- vin_l_ena, vin_r_ena  out  1 each  VIN enables.
- lpan, rpan  out  NUM_CH each  per-channel panning.
- len_tick, sweep_tick, env_tick  out  1 each  single-cycle sequencer pulses.
- fs_step  out  $clog2(FS_STEPS)  current sequencer step.

Behaviour:
- Reset (async):
  - All outputs 0, except ch_reset = 1.
  - apu_on = 0; registers, dividers and fs_step = 0; edge-detect flop = 0.
- Clock dividers:
  - ajer_2mhz toggles every clock while apu_on.
  - dyfa_1mhz toggles on each 1->0 transition of ajer_2mhz.
  - Both are held at 0 while off.
- Writes take effect on the clock edge where cpu_wr is high. Readback reflects the new value from the next cycle.
- Volume register: bit 7 = vin_l_ena, bits [6:4] = lvol, bit 3 = vin_r_ena, bits [2:0] = rvol. Bits above VOL_W are not stored and read 0.
- Pan register:
  - Bits [3:0] = rpan, bits [7:4] = lpan, low NUM_CH bits of each nibble.
  - Unimplemented pan bits read 1.
- Power/status register:
  - Write bit 7 sets apu_on; other written bits are ignored, except under the optional feature.
  - Read: bit 7 = apu_on, bits [6:4] = 111, bits [3:0] = ch_active (unimplemented channels read 0). Channel status bits read 0 while off.
- Power-off (write bit 7 = 0 while on):
  - Next cycle: volume and pan registers, dividers, fs_step and all ticks are cleared; ch_reset = 1.
  - While off, writes to volume and pan are ignored. Power-register writes are still accepted.
- Power-on (write bit 7 = 1 while off):
  - ch_reset falls on the same edge that apu_on rises.
  - fs_step starts at 0.
  - A 1 written to an already-on APU has no effect: no reset, no step clear.
- Frame sequencer:
  - The rising edge of fs_tick_in is sampled by one flop; detection adds one cycle of latency.
  - On a detected edge while on, pulses are issued for the current fs_step, then fs_step increments modulo FS_STEPS.
  - len_tick on even steps.
  - sweep_tick on steps 2 and 6 (mod 8 pattern, repeated for FS_STEPS > 8; step 2 only for FS_STEPS = 4).
  - env_tick on step FS_STEPS-1.
  - Each pulse is exactly one clock wide.
- Simultaneous events:
  - A power-off write in the same cycle as a tick edge: power-off wins; no pulse is issued.
  - cpu_rd and cpu_wr in the same cycle: rdata shows the old value.

Optional Feature:
- Macro: APU_FAST_SEQ_EN.
- With the macro defined:
  - Writing power-register bit 4 = 1 with t1_nt2 = 1 sets a fast_seq flop.
  - While fast_seq is set, the sequencer advances on every dyfa_1mhz rising edge instead of fs_tick_in.
  - fast_seq is cleared by a write with bit 4 = 0, by power-off, and by reset.
  - fast_seq is readable as rdata bit 4 while t1_nt2 = 1.
- Without the macro: bit 4 is ignored and reads 1.

Decomposition:
- Package apu_pkg holds:
  - the reg_sel enum (REG_VOL, REG_PAN, REG_PWR, REG_NONE);
  - bit-position constants for the three registers;
  - the step-to-tick decode function.
- Sub-module apu_frame_seq: edge detect, step counter and tick decode, parametrised by FS_STEPS.

Test Plan:
- Reset, then read power register -> rdata = 8'h70; ch_reset = 1; ajer_2mhz static at 0.
- Write power 8'h80, pan 8'hF3, volume 8'h77 -> lpan = 4'hF, rpan = 4'h3, lvol = rvol = 7; pan reads 8'hF3.
- Power on, ch_active = 4'b0101, read power -> 8'hF5; write power 8'h00 -> next read 8'h70, pan/volume read 8'h00, ch_reset = 1.
- With the APU on, pulse fs_tick_in 8 times -> len_tick 4 times at steps 0,2,4,6; sweep_tick at steps 2,6; env_tick once at step 7; fs_step wraps to 0.
- Power-off write in the same cycle as a tick edge -> no tick pulse; fs_step = 0.
- APU_FAST_SEQ_EN defined, t1_nt2 = 1, write power 8'h90 -> fs_step advances every 4 clocks; read power bit 4 = 1.
